// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage,
// carry registered between stages, operands skewed in and sum bits de-skewed out.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / GROUP;

  if (WIDTH % GROUP != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic [STAGES:0]  cy;
  logic [STAGES:0]  vld;
  logic             ovf_q;

  // Subtraction is a + ~b + ~borrow; the whole pipe freezes while the output is blocked.
  assign stall     = vld[STAGES] & ~out_ready;
  assign in_ready  = ~stall;
  assign b_eff     = sub ? ~b : b;
  assign cy[0]     = sub ^ c_in;
  assign vld[0]    = in_valid;
  assign out_valid = vld[STAGES];
  assign c_out     = cy[STAGES];
  assign ovf       = ovf_q;

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    logic [GROUP-1:0]                  op_a;
    logic [GROUP-1:0]                  op_b;
    logic [GROUP-1:0]                  gen;
    logic [GROUP-1:0]                  prop;
    logic [GROUP-1:0]                  grp_sum;
    logic [GROUP:0]                    cl;
    logic                              term;
    logic [STAGES-j-1:0][GROUP-1:0]    sum_q;
    logic                              cy_q;
    logic                              vld_q;

    if (j == 0) begin : g_src
      assign op_a = a[GROUP-1:0];
      assign op_b = b_eff[GROUP-1:0];
    end else begin : g_src
      // Group j operands wait j cycles so they meet the carry coming up from below.
      logic [j-1:0][GROUP-1:0] a_q;
      logic [j-1:0][GROUP-1:0] b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q[0] <= a[j*GROUP +: GROUP];
          b_q[0] <= b_eff[j*GROUP +: GROUP];
          for (int i = 1; i < j; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
        end
      end
      assign op_a = a_q[j-1];
      assign op_b = b_q[j-1];
    end

    // Each carry is the flat sum-of-products of g/p terms plus the incoming carry.
    always_comb begin
      gen  = op_a & op_b;
      prop = op_a ^ op_b;
      cl   = '0;
      term = 1'b0;
      for (int i = 0; i <= GROUP; i++) begin
        cl[i] = cy[j];
        for (int m = 0; m < i; m++) cl[i] = cl[i] & prop[m];
        for (int n = 0; n < i; n++) begin
          term = gen[n];
          for (int m = n + 1; m < i; m++) term = term & prop[m];
          cl[i] = cl[i] | term;
        end
      end
      grp_sum = prop ^ cl[GROUP-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q <= '0;
        cy_q  <= 1'b0;
        vld_q <= 1'b0;
      end else if (!stall) begin
        sum_q[0] <= grp_sum;
        for (int i = 1; i < STAGES - j; i++) sum_q[i] <= sum_q[i-1];
        cy_q  <= cl[GROUP];
        vld_q <= vld[j];
      end
    end

    assign cy[j+1]                 = cy_q;
    assign vld[j+1]                = vld_q;
    assign sum[j*GROUP +: GROUP]   = sum_q[STAGES-j-1];

    if (j == STAGES - 1) begin : g_flag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else if (!stall) ovf_q <= cl[GROUP] ^ cl[GROUP-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomized checks of cla_pipe_adder at 16/4, 32/8 and 8/8.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [15:0] a, b, sum;
  logic        w_in_valid, w_in_ready, w_c_in, w_sub, w_out_valid, w_out_ready, w_c_out, w_ovf;
  logic [31:0] w_a, w_b, w_sum;
  logic        n_in_valid, n_in_ready, n_c_in, n_sub, n_out_valid, n_out_ready, n_c_out, n_ovf;
  logic [7:0]  n_a, n_b, n_sum;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf));

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
    .c_in(w_c_in), .sub(w_sub), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .c_out(w_c_out), .ovf(w_ovf));

  cla_pipe_adder #(.WIDTH(8), .GROUP(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .a(n_a), .b(n_b),
    .c_in(n_c_in), .sub(n_sub), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .sum(n_sum), .c_out(n_c_out), .ovf(n_ovf));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {carry, overflow, sum} for a w-bit add/sub, built from plain integer arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] xa, input logic [31:0] xb,
                                        input logic xc, input logic xs);
    logic [32:0] full, low;
    logic [31:0] mask, bb;
    logic        ci, co, cm;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    bb   = (xs ? ~xb : xb) & mask;
    ci   = xs ^ xc;
    full = {1'b0, xa & mask} + {1'b0, bb} + {32'b0, ci};
    low  = {1'b0, xa & (mask >> 1)} + {1'b0, bb & (mask >> 1)} + {32'b0, ci};
    co   = full[w];
    cm   = low[w-1];
    return {co, cm ^ co, full[31:0] & mask};
  endfunction

  // One isolated operation on the 16-bit unit; checks latency and {c_out, ovf, sum}.
  task automatic op16(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                      input logic xc, input logic xs, input logic [17:0] exp);
    int n;
    in_valid = 1'b1; a = xa; b = xb; c_in = xc; sub = xs;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk(tag, {c_out, ovf, sum}, exp);
  endtask

  initial begin
    int n, sent, rcv, cyc, first, seen;
    logic [33:0] q[$];

    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; c_in = 0; sub = 0; out_ready = 1;
    w_in_valid = 0; w_a = 0; w_b = 0; w_c_in = 0; w_sub = 0; w_out_ready = 1;
    n_in_valid = 0; n_a = 0; n_b = 0; n_c_in = 0; n_sub = 0; n_out_ready = 1;
    tick();
    tick();
    chk("reset_outs", {out_valid, c_out, ovf, sum}, 19'h0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);

    // Directed vectors, expected as {c_out, ovf, sum}.
    op16("add_basic",  16'h0004, 16'h0005, 1'b1, 1'b0, {2'b00, 16'h000A});
    op16("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {2'b10, 16'h0000});
    op16("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, {2'b01, 16'h8000});
    op16("add_neg_ovf",16'h8000, 16'h8000, 1'b0, 1'b0, {2'b11, 16'h0000});
    op16("add_grp",    16'h0FF0, 16'h0010, 1'b0, 1'b0, {2'b00, 16'h1000});
    op16("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, {2'b10, 16'h0002});
    op16("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, {2'b00, 16'hFFFE});
    op16("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, {2'b11, 16'h7FFF});
    op16("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, {2'b10, 16'h000E});
    tick();

    // Backpressure: six back-to-back adds, out_ready dropped for three cycles.
    sent = 0; rcv = 0; first = -1; cyc = 0;
    while (rcv < 6 && cyc < 40) begin
      if (out_valid && first < 0) first = cyc;
      out_ready = !(first >= 0 && cyc > first && cyc <= first + 3);
      in_valid = (sent < 6);
      a = 16'h0010; b = 16'(sent + 1); c_in = 0; sub = 0;
      #1;
      if (!out_ready) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold", {out_valid, sum}, {1'b1, 16'h0010 + 16'(rcv + 1)});
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("bp_order", sum, 16'h0010 + 16'(rcv + 1));
        rcv++;
      end
      tick();
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    chk("bp_count", rcv, 6);

    // Reset while three operations are in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = 16'h1111 * 16'(i + 1); b = 16'h0001; c_in = 0; sub = 0;
      tick();
    end
    in_valid = 0;
    tick();
    chk("rst_pre", {out_valid, sum}, {1'b1, 16'h1112});
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {out_valid, c_out, ovf, sum}, 19'h0);
    tick();
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_no_stale", seen, 0);
    op16("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, {2'b00, 16'h5555});

    // 32/8: directed latency check, then random stream with random backpressure.
    w_in_valid = 1; w_a = 32'h89AB_CDEF; w_b = 32'h7654_3211; w_c_in = 0; w_sub = 0;
    tick();
    w_in_valid = 0; n = 1;
    while (!w_out_valid && n < 20) begin tick(); n++; end
    chk("w32_lat", n, 4);
    chk("w32_dir", {w_c_out, w_ovf, w_sum}, {2'b10, 32'h0});
    tick();
    q.delete(); sent = 0; rcv = 0; cyc = 0;
    while (rcv < 1000 && cyc < 10000) begin
      w_in_valid  = (sent < 1000) && ($urandom_range(0, 4) != 0);
      w_a = $urandom; w_b = $urandom;
      w_c_in = 1'($urandom_range(0, 1)); w_sub = 1'($urandom_range(0, 1));
      w_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (w_in_valid && w_in_ready) begin
        q.push_back(model(32, w_a, w_b, w_c_in, w_sub));
        sent++;
      end
      if (w_out_valid && w_out_ready) begin
        if (q.size() == 0) chk("w32_spurious", 1, 0);
        else chk("w32_rand", {w_c_out, w_ovf, w_sum}, q.pop_front());
        rcv++;
      end
      tick();
      cyc++;
    end
    w_in_valid = 0; w_out_ready = 1;
    chk("w32_count", rcv, 1000);

    // 8/8: single-stage degenerate case.
    n_in_valid = 1; n_a = 8'h7F; n_b = 8'h01; n_c_in = 0; n_sub = 0;
    tick();
    n_in_valid = 0; n = 1;
    while (!n_out_valid && n < 20) begin tick(); n++; end
    chk("w8_lat", n, 1);
    chk("w8_dir", {n_c_out, n_ovf, n_sum}, {2'b01, 8'h80});
    tick();
    q.delete(); sent = 0; rcv = 0; cyc = 0;
    while (rcv < 1000 && cyc < 10000) begin
      n_in_valid  = (sent < 1000) && ($urandom_range(0, 4) != 0);
      n_a = 8'($urandom_range(0, 255)); n_b = 8'($urandom_range(0, 255));
      n_c_in = 1'($urandom_range(0, 1)); n_sub = 1'($urandom_range(0, 1));
      n_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (n_in_valid && n_in_ready) begin
        q.push_back(model(8, {24'b0, n_a}, {24'b0, n_b}, n_c_in, n_sub));
        sent++;
      end
      if (n_out_valid && n_out_ready) begin
        if (q.size() == 0) chk("w8_spurious", 1, 0);
        else chk("w8_rand", {n_c_out, n_ovf, 24'b0, n_sum}, q.pop_front());
        rcv++;
      end
      tick();
      cyc++;
    end
    n_in_valid = 0; n_out_ready = 1;
    chk("w8_count", rcv, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
